ula_banco_operandos: RTL and testbench

Operand-supply and result-capture stage wrapped around the 32-bit ULA: holds a small register bank, accepts commands over a valid/ready handshake, drives the ULA operand and function inputs from registered latches, and writes the ULA result back into the bank. The ULA itself stays outside this block and is connected through the `ula_*` ports. Results and the ULA overflow pin are returned on a response handshake.

---
 rtl/ula_banco_operandos_pkg.sv | 19 +
 rtl/ula_banco_operandos_regs.sv | 34 +++
 rtl/ula_banco_operandos.sv | 148 ++++++++++++++
 tb/tb_ula_banco_operandos.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ula_banco_operandos_pkg.sv
// Shared types for the ULA operand/result stage: default width, command opcodes, FSM states.
package ula_pkg;

   localparam int unsigned W_DEF = 32;

   typedef enum logic [1:0] {
      OP_LOAD = 2'b00,
      OP_ALU  = 2'b01,
      OP_READ = 2'b10,
      OP_RSV  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StExec = 2'b01,
      StResp = 2'b10
   } state_e;

endpackage

// File: rtl/ula_banco_operandos_regs.sv
// NREG x W register bank: two asynchronous read ports, one synchronous write port,
// asynchronous active-low clear.
module ula_banco_regs #(
   parameter int unsigned W    = 32,
   parameter int unsigned NREG = 8,
   localparam int unsigned AW  = $clog2(NREG)
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [W-1:0]  i_wdata,
   input  logic [AW-1:0] i_raddr_a,
   output logic [W-1:0]  o_rdata_a,
   input  logic [AW-1:0] i_raddr_b,
   output logic [W-1:0]  o_rdata_b
);

   logic [W-1:0] r_mem [NREG];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata_a = r_mem[i_raddr_a];
   assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/ula_banco_operandos.sv
// Operand-supply and result-capture stage around an external ULA: command handshake in,
// registered operands out, ULA result written back to the bank and returned as a response.
module ula_banco_operandos
   import ula_pkg::*;
#(
   parameter int unsigned W    = W_DEF,
   parameter int unsigned NREG = 8,
   localparam int unsigned AW  = $clog2(NREG)
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_cmd_valid,
   output logic          o_cmd_ready,
   input  logic [1:0]    i_cmd_op,
   input  logic [2:0]    i_cmd_func,
   input  logic [AW-1:0] i_cmd_rd,
   input  logic [AW-1:0] i_cmd_ra,
   input  logic [AW-1:0] i_cmd_rb,
   input  logic [W-1:0]  i_cmd_imm,
   output logic [W-1:0]  o_ula_a,
   output logic [W-1:0]  o_ula_b,
   output logic [2:0]    o_ula_func,
   input  logic [W-1:0]  i_ula_r,
   input  logic          i_ula_v,
   output logic          o_rsp_valid,
   input  logic          i_rsp_ready,
   output logic [W-1:0]  o_rsp_data,
   output logic          o_rsp_v,
   output logic          o_rsp_err
);

   state_e        r_state;
   logic [W-1:0]  r_ula_a;
   logic [W-1:0]  r_ula_b;
   logic [2:0]    r_ula_func;
   logic [AW-1:0] r_rd;
   logic          r_rsp_valid;
   logic [W-1:0]  r_rsp_data;
   logic          r_rsp_v;
   logic          r_rsp_err;

   op_e           w_op;
   logic          w_accept;
   logic          w_we;
   logic [AW-1:0] w_waddr;
   logic [W-1:0]  w_wdata;
   logic [W-1:0]  w_rdata_a;
   logic [W-1:0]  w_rdata_b;

   assign w_op     = op_e'(i_cmd_op);
   assign w_accept = (r_state == StIdle) && i_cmd_valid;

   // Only two writers: LOAD on its accept edge, ALU result on the EXEC edge.
   assign w_we    = (w_accept && (w_op == OP_LOAD)) || (r_state == StExec);
   assign w_waddr = (r_state == StExec) ? r_rd : i_cmd_rd;
   assign w_wdata = (r_state == StExec) ? i_ula_r : i_cmd_imm;

   ula_banco_regs #(
      .W    (W),
      .NREG (NREG)
   ) u_regs (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_we      (w_we),
      .i_waddr   (w_waddr),
      .i_wdata   (w_wdata),
      .i_raddr_a (i_cmd_ra),
      .o_rdata_a (w_rdata_a),
      .i_raddr_b (i_cmd_rb),
      .o_rdata_b (w_rdata_b)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= StIdle;
         r_ula_a     <= '0;
         r_ula_b     <= '0;
         r_ula_func  <= '0;
         r_rd        <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_v     <= 1'b0;
         r_rsp_err   <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (i_cmd_valid) begin
                  case (w_op)
                     OP_ALU: begin
                        r_ula_a    <= w_rdata_a;
                        r_ula_b    <= w_rdata_b;
                        r_ula_func <= i_cmd_func;
                        r_rd       <= i_cmd_rd;
                        r_state    <= StExec;
                     end
                     OP_LOAD: begin
                        r_rsp_data  <= i_cmd_imm;
                        r_rsp_v     <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= StResp;
                     end
                     OP_READ: begin
                        r_rsp_data  <= w_rdata_a;
                        r_rsp_v     <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= StResp;
                     end
                     default: begin
                        r_rsp_data  <= '0;
                        r_rsp_v     <= 1'b0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= StResp;
                     end
                  endcase
               end
            end
            StExec: begin
               // ULA has had the whole EXEC cycle to settle on the latched operands.
               r_rsp_data  <= i_ula_r;
               r_rsp_v     <= i_ula_v;
               r_rsp_err   <= 1'b0;
               r_rsp_valid <= 1'b1;
               r_state     <= StResp;
            end
            StResp: begin
               if (i_rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign o_cmd_ready = (r_state == StIdle);
   assign o_ula_a     = r_ula_a;
   assign o_ula_b     = r_ula_b;
   assign o_ula_func  = r_ula_func;
   assign o_rsp_valid = r_rsp_valid;
   assign o_rsp_data  = r_rsp_data;
   assign o_rsp_v     = r_rsp_v;
   assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_ula_banco_operandos.sv
// Bench for ula_banco_operandos: directed vector table, backpressure and mid-EXEC reset
// sequences, then random commands against a register-array model with a behavioural ULA stub.
module tb_ula_banco_operandos;

   logic        clk;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [2:0]  cmd_func;
   logic [2:0]  cmd_rd;
   logic [2:0]  cmd_ra;
   logic [2:0]  cmd_rb;
   logic [31:0] cmd_imm;
   logic [31:0] ula_a;
   logic [31:0] ula_b;
   logic [2:0]  ula_func;
   logic [31:0] ula_r;
   logic        ula_v;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_v;
   logic        rsp_err;

   int checks;
   int failures;

   logic        stub_en;
   logic [31:0] stub_r;
   logic        stub_v;

   logic [31:0] model [8];
   logic [31:0] last_a;
   logic [31:0] last_b;
   logic [2:0]  last_func;

   ula_banco_operandos dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_cmd_valid (cmd_valid),
      .o_cmd_ready (cmd_ready),
      .i_cmd_op    (cmd_op),
      .i_cmd_func  (cmd_func),
      .i_cmd_rd    (cmd_rd),
      .i_cmd_ra    (cmd_ra),
      .i_cmd_rb    (cmd_rb),
      .i_cmd_imm   (cmd_imm),
      .o_ula_a     (ula_a),
      .o_ula_b     (ula_b),
      .o_ula_func  (ula_func),
      .i_ula_r     (ula_r),
      .i_ula_v     (ula_v),
      .o_rsp_valid (rsp_valid),
      .i_rsp_ready (rsp_ready),
      .o_rsp_data  (rsp_data),
      .o_rsp_v     (rsp_v),
      .o_rsp_err   (rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural stand-in for the external ULA.
   function automatic logic [32:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] f);
      longint sa;
      longint sb;
      longint s;
      logic [31:0] r;
      logic v;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      v  = 1'b0;
      case (f)
         3'd0: r = a & b;
         3'd1: r = a | b;
         3'd2: begin s = sa + sb; r = a + b; v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
         3'd3: begin s = sa - sb; r = a - b; v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
         3'd4: r = a ^ b;
         default: r = ~a;
      endcase
      return {v, r};
   endfunction

   always_comb begin
      ula_r = 32'h0;
      ula_v = 1'b0;
      if (stub_en) begin
         ula_r = stub_r;
         ula_v = stub_v;
      end else begin
         {ula_v, ula_r} = ref_alu(ula_a, ula_b, ula_func);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Issues one command with rsp_ready high; returns response and latency in cycles.
   task automatic run_cmd(input logic [1:0] op, input logic [2:0] func, input logic [2:0] rd,
                          input logic [2:0] ra, input logic [2:0] rb, input logic [31:0] imm,
                          output logic [31:0] d, output logic v, output logic e, output int lat,
                          output logic [31:0] sa, output logic [31:0] sb,
                          output logic [2:0] sf);
      @(negedge clk);
      chk("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_func  = func;
      cmd_rd    = rd;
      cmd_ra    = ra;
      cmd_rb    = rb;
      cmd_imm   = imm;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      lat = 0;
      sa = '0;
      sb = '0;
      sf = '0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 1) begin
            sa = ula_a;
            sb = ula_b;
            sf = ula_func;
         end
         if (rsp_valid) begin
            lat = k;
            break;
         end
      end
      if (lat == 0) begin
         checks++;
         failures++;
         $display("FAIL rsp_timeout: got no rsp_valid expected within 8 cycles");
      end
      d = rsp_data;
      v = rsp_v;
      e = rsp_err;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [1:0]  op;
      logic [2:0]  func;
      logic [2:0]  rd;
      logic [2:0]  ra;
      logic [2:0]  rb;
      logic [31:0] imm;
      logic        sen;
      logic [31:0] sr;
      logic        sv;
      logic [31:0] ed;
      logic        ev;
      logic        ee;
   } vec_t;

   vec_t tbl [12];

   initial begin
      logic [31:0] d;
      logic        v;
      logic        e;
      int          lat;
      logic [31:0] sa;
      logic [31:0] sb;
      logic [2:0]  sf;
      logic [32:0] ref_res;
      logic [31:0] exp_d;

      tbl[0]  = '{2'b10, 3'd0, 3'd0, 3'd5, 3'd0, 32'h0,    1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0};
      tbl[1]  = '{2'b00, 3'd0, 3'd1, 3'd0, 3'd0, 32'h5,    1'b0, 32'h0,        1'b0, 32'h5,        1'b0, 1'b0};
      tbl[2]  = '{2'b00, 3'd0, 3'd2, 3'd0, 3'd0, 32'h3,    1'b0, 32'h0,        1'b0, 32'h3,        1'b0, 1'b0};
      tbl[3]  = '{2'b01, 3'd2, 3'd3, 3'd1, 3'd2, 32'h0,    1'b1, 32'h8,        1'b0, 32'h8,        1'b0, 1'b0};
      tbl[4]  = '{2'b10, 3'd0, 3'd0, 3'd3, 3'd0, 32'h0,    1'b0, 32'h0,        1'b0, 32'h8,        1'b0, 1'b0};
      tbl[5]  = '{2'b01, 3'd2, 3'd4, 3'd1, 3'd2, 32'h0,    1'b1, 32'h80000000, 1'b1, 32'h80000000, 1'b1, 1'b0};
      tbl[6]  = '{2'b00, 3'd0, 3'd6, 3'd0, 3'd0, 32'h1234, 1'b0, 32'h0,        1'b0, 32'h1234,     1'b0, 1'b0};
      tbl[7]  = '{2'b10, 3'd0, 3'd0, 3'd4, 3'd0, 32'h0,    1'b0, 32'h0,        1'b0, 32'h80000000, 1'b0, 1'b0};
      tbl[8]  = '{2'b11, 3'd0, 3'd1, 3'd2, 3'd0, 32'hFF,   1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1};
      tbl[9]  = '{2'b10, 3'd0, 3'd0, 3'd1, 3'd0, 32'h0,    1'b0, 32'h0,        1'b0, 32'h5,        1'b0, 1'b0};
      tbl[10] = '{2'b01, 3'd2, 3'd1, 3'd1, 3'd1, 32'h0,    1'b0, 32'h0,        1'b0, 32'hA,        1'b0, 1'b0};
      tbl[11] = '{2'b10, 3'd0, 3'd0, 3'd1, 3'd0, 32'h0,    1'b0, 32'h0,        1'b0, 32'hA,        1'b0, 1'b0};

      checks = 0;
      failures = 0;
      stub_en = 1'b0;
      stub_r = '0;
      stub_v = 1'b0;
      for (int i = 0; i < 8; i++) model[i] = '0;
      last_a = '0;
      last_b = '0;
      last_func = '0;
      rst_n = 1'b0;
      cmd_valid = 1'b0;
      cmd_op = '0;
      cmd_func = '0;
      cmd_rd = '0;
      cmd_ra = '0;
      cmd_rb = '0;
      cmd_imm = '0;
      rsp_ready = 1'b1;

      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rst_ula_a", ula_a, 32'd0);
      chk("rst_ula_b", ula_b, 32'd0);
      chk("rst_ula_func", {29'b0, ula_func}, 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);

      for (int i = 0; i < 12; i++) begin
         stub_en = tbl[i].sen;
         stub_r  = tbl[i].sr;
         stub_v  = tbl[i].sv;
         run_cmd(tbl[i].op, tbl[i].func, tbl[i].rd, tbl[i].ra, tbl[i].rb, tbl[i].imm,
                 d, v, e, lat, sa, sb, sf);
         chk($sformatf("vec%0d_data", i), d, tbl[i].ed);
         chk($sformatf("vec%0d_v", i), {31'b0, v}, {31'b0, tbl[i].ev});
         chk($sformatf("vec%0d_err", i), {31'b0, e}, {31'b0, tbl[i].ee});
         chk($sformatf("vec%0d_lat", i), lat, (tbl[i].op == 2'b01) ? 32'd2 : 32'd1);
         if (tbl[i].op == 2'b01) begin
            chk($sformatf("vec%0d_exec_a", i), sa, model[tbl[i].ra]);
            chk($sformatf("vec%0d_exec_b", i), sb, model[tbl[i].rb]);
            chk($sformatf("vec%0d_exec_f", i), {29'b0, sf}, {29'b0, tbl[i].func});
            last_a = model[tbl[i].ra];
            last_b = model[tbl[i].rb];
            last_func = tbl[i].func;
            model[tbl[i].rd] = tbl[i].ed;
         end else if (tbl[i].op == 2'b00) begin
            model[tbl[i].rd] = tbl[i].imm;
         end
         chk($sformatf("vec%0d_hold_a", i), ula_a, last_a);
      end
      stub_en = 1'b0;

      // Backpressure: response held, a pending LOAD waits for the cycle after rsp_ready rises.
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op = 2'b00;
      cmd_rd = 3'd7;
      cmd_imm = 32'hA5A5_0F0F;
      rsp_ready = 1'b0;
      @(posedge clk);
      #1;
      cmd_rd = 3'd0;
      cmd_imm = 32'h0000_0077;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
         chk("bp_rsp_data", rsp_data, 32'hA5A5_0F0F);
         chk("bp_cmd_ready", {31'b0, cmd_ready}, 32'd0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_valid", {31'b0, rsp_valid}, 32'd0);
      chk("bp_release_ready", {31'b0, cmd_ready}, 32'd1);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(negedge clk);
      chk("bp_pending_valid", {31'b0, rsp_valid}, 32'd1);
      chk("bp_pending_data", rsp_data, 32'h0000_0077);
      @(posedge clk);
      #1;
      model[7] = 32'hA5A5_0F0F;
      model[0] = 32'h0000_0077;
      run_cmd(2'b10, 3'd0, 3'd0, 3'd7, 3'd0, 32'h0, d, v, e, lat, sa, sb, sf);
      chk("bp_read_r7", d, 32'hA5A5_0F0F);

      // Reset during EXEC: no write-back, bank cleared.
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op = 2'b01;
      cmd_func = 3'd2;
      cmd_rd = 3'd2;
      cmd_ra = 3'd7;
      cmd_rb = 3'd7;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_exec_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) model[i] = '0;
      last_a = '0;
      last_b = '0;
      last_func = '0;
      for (int i = 0; i < 8; i++) begin
         run_cmd(2'b10, 3'd0, 3'd0, 3'(i), 3'd0, 32'h0, d, v, e, lat, sa, sb, sf);
         chk($sformatf("rst_exec_r%0d", i), d, 32'd0);
      end

      // Random commands against the model.
      for (int n = 0; n < 60; n++) begin
         int sel;
         logic [1:0]  op;
         logic [2:0]  func;
         logic [2:0]  rd;
         logic [2:0]  ra;
         logic [2:0]  rb;
         logic [31:0] imm;
         logic        exp_v;
         logic        exp_e;
         sel  = $urandom_range(0, 9);
         op   = (sel < 3) ? 2'b00 : (sel < 6) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
         func = 3'($urandom_range(0, 7));
         rd   = 3'($urandom_range(0, 7));
         ra   = 3'($urandom_range(0, 7));
         rb   = 3'($urandom_range(0, 7));
         imm  = $urandom;
         if ($urandom_range(0, 3) == 0) imm = 32'h7FFF_FFFF + 32'($urandom_range(0, 2));
         exp_v = 1'b0;
         exp_e = 1'b0;
         case (op)
            2'b00: exp_d = imm;
            2'b01: begin
               ref_res = ref_alu(model[ra], model[rb], func);
               exp_d = ref_res[31:0];
               exp_v = ref_res[32];
            end
            2'b10: exp_d = model[ra];
            default: begin
               exp_d = '0;
               exp_e = 1'b1;
            end
         endcase
         run_cmd(op, func, rd, ra, rb, imm, d, v, e, lat, sa, sb, sf);
         chk($sformatf("rnd%0d_op%0d_data", n, op), d, exp_d);
         chk($sformatf("rnd%0d_op%0d_v", n, op), {31'b0, v}, {31'b0, exp_v});
         chk($sformatf("rnd%0d_op%0d_err", n, op), {31'b0, e}, {31'b0, exp_e});
         chk($sformatf("rnd%0d_op%0d_lat", n, op), lat, (op == 2'b01) ? 32'd2 : 32'd1);
         if (op == 2'b01) begin
            last_a = model[ra];
            last_b = model[rb];
            last_func = func;
            model[rd] = exp_d;
         end else if (op == 2'b00) begin
            model[rd] = imm;
         end
         chk($sformatf("rnd%0d_hold_a", n), ula_a, last_a);
         chk($sformatf("rnd%0d_hold_b", n), ula_b, last_b);
         chk($sformatf("rnd%0d_hold_f", n), {29'b0, ula_func}, {29'b0, last_func});
      end

      for (int i = 0; i < 8; i++) begin
         run_cmd(2'b10, 3'd0, 3'd0, 3'(i), 3'd0, 32'h0, d, v, e, lat, sa, sb, sf);
         chk($sformatf("final_r%0d", i), d, model[i]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion expected finish before 500000");
      $fatal(1, "watchdog expired");
   end

endmodule
